// File: rtl/rs_sched_if.sv
// Dispatch, CDB wakeup and issue signals of the reservation-station scheduler.
// The master side is the dispatch/CDB/execute environment and the slave side is the scheduler.
interface rs_sched_if #(
    parameter int RS_SIZE = 16,
    parameter int TAG_W   = 6,
    parameter int IDX_W   = $clog2(RS_SIZE)
);
    // Handshakes: a dispatch transfers on a cycle with disp_valid && disp_ready.
    // An issue transfers on a cycle with iss_valid && iss_ready.
    // Once iss_valid is raised, iss_idx stays stable until that transfer happens.
    logic               disp_valid;
    logic               disp_ready;
    logic [TAG_W-1:0]   disp_tag1;
    logic [TAG_W-1:0]   disp_tag2;
    logic [IDX_W-1:0]   disp_idx;
    logic               cdb_valid;
    logic [TAG_W-1:0]   cdb_tag;
    logic               iss_valid;
    logic [IDX_W-1:0]   iss_idx;
    logic               iss_ready;
    logic [RS_SIZE-1:0] busy_vec;
    logic [IDX_W:0]     occupancy;
    logic               dbg_lock;

    modport master (
        output disp_valid, disp_tag1, disp_tag2, cdb_valid, cdb_tag, iss_ready,
        input  disp_ready, disp_idx, iss_valid, iss_idx, busy_vec, occupancy, dbg_lock
    );

    modport slave (
        input  disp_valid, disp_tag1, disp_tag2, cdb_valid, cdb_tag, iss_ready,
        output disp_ready, disp_idx, iss_valid, iss_idx, busy_vec, occupancy, dbg_lock
    );
endinterface

// File: rtl/rs_scheduler.sv
// Reservation-station allocate/wakeup/select with an age matrix for oldest-ready selection.
// Selection is held stable while the execute port stalls.
module rs_scheduler #(
    parameter int RS_SIZE = 16,
    parameter int TAG_W   = 6,
    parameter int IDX_W   = $clog2(RS_SIZE)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    rs_sched_if.slave    bus
);
    typedef enum logic {SEL_OPEN = 1'b0, SEL_HELD = 1'b1} sel_state_e;

    logic [RS_SIZE-1:0] busy_q, busy_d;
    logic [TAG_W-1:0]   tag1_q [RS_SIZE];
    logic [TAG_W-1:0]   tag1_d [RS_SIZE];
    logic [TAG_W-1:0]   tag2_q [RS_SIZE];
    logic [TAG_W-1:0]   tag2_d [RS_SIZE];
    logic [RS_SIZE-1:0] older_q [RS_SIZE];
    logic [RS_SIZE-1:0] older_d [RS_SIZE];
    sel_state_e         state_q, state_d;
    logic [IDX_W-1:0]   lock_idx_q, lock_idx_d;

    logic [RS_SIZE-1:0] ready;
    logic [RS_SIZE-1:0] blocked;
    logic [IDX_W-1:0]   free_idx;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W:0]     occ;
    logic               disp_fire;
    logic               iss_fire;
    logic               cdb_hit;
    logic [TAG_W-1:0]   wtag1, wtag2;

    always_comb begin : alloc_select
        free_idx = '0;
        pick_idx = '0;
        occ      = '0;
        ready    = '0;
        blocked  = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy_q[i]) free_idx = IDX_W'(i);
        end
        for (int i = 0; i < RS_SIZE; i++) begin
            occ      = occ + {{IDX_W{1'b0}}, busy_q[i]};
            ready[i] = busy_q[i] && (tag1_q[i] == '0) && (tag2_q[i] == '0);
        end
        // An entry is blocked when some other ready entry is older than it.
        for (int i = 0; i < RS_SIZE; i++) begin
            for (int j = 0; j < RS_SIZE; j++) begin
                if (j != i && ready[j] && older_q[j][i]) blocked[i] = 1'b1;
            end
        end
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (ready[i] && !blocked[i]) pick_idx = IDX_W'(i);
        end
    end

    assign bus.disp_ready = (occ != (IDX_W+1)'(RS_SIZE));
    assign bus.disp_idx   = free_idx;
    assign bus.iss_valid  = (state_q == SEL_HELD) || (|ready);
    assign bus.iss_idx    = (state_q == SEL_HELD) ? lock_idx_q : pick_idx;
    assign bus.busy_vec   = busy_q;
    assign bus.occupancy  = occ;
    assign bus.dbg_lock   = (state_q == SEL_HELD);

    assign disp_fire = bus.disp_valid && bus.disp_ready;
    assign iss_fire  = bus.iss_valid && bus.iss_ready;
    assign cdb_hit   = bus.cdb_valid && (bus.cdb_tag != '0);
    assign wtag1     = (cdb_hit && bus.disp_tag1 == bus.cdb_tag) ? '0 : bus.disp_tag1;
    assign wtag2     = (cdb_hit && bus.disp_tag2 == bus.cdb_tag) ? '0 : bus.disp_tag2;

    always_comb begin : next_state
        busy_d     = busy_q;
        tag1_d     = tag1_q;
        tag2_d     = tag2_q;
        older_d    = older_q;
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        if (flush) begin
            busy_d     = '0;
            state_d    = SEL_OPEN;
            lock_idx_d = '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                tag1_d[i]  = '0;
                tag2_d[i]  = '0;
                older_d[i] = '0;
            end
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy_q[i] && cdb_hit && tag1_q[i] == bus.cdb_tag) tag1_d[i] = '0;
                if (busy_q[i] && cdb_hit && tag2_q[i] == bus.cdb_tag) tag2_d[i] = '0;
            end
            case (state_q)
                SEL_OPEN: begin
                    if (bus.iss_valid && !bus.iss_ready) begin
                        state_d    = SEL_HELD;
                        lock_idx_d = pick_idx;
                    end
                end
                SEL_HELD: begin
                    if (bus.iss_ready) state_d = SEL_OPEN;
                end
                default: state_d = SEL_OPEN;
            endcase
            if (iss_fire) busy_d[bus.iss_idx] = 1'b0;
            // The allocated entry was not busy before this edge, so it never collides with the issued one.
            if (disp_fire) begin
                busy_d[free_idx]  = 1'b1;
                tag1_d[free_idx]  = wtag1;
                tag2_d[free_idx]  = wtag2;
                older_d[free_idx] = '0;
                for (int j = 0; j < RS_SIZE; j++) begin
                    if (busy_q[j]) older_d[j][free_idx] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q     <= '0;
            state_q    <= SEL_OPEN;
            lock_idx_q <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                tag1_q[i]  <= '0;
                tag2_q[i]  <= '0;
                older_q[i] <= '0;
            end
        end else begin
            busy_q     <= busy_d;
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
            for (int i = 0; i < RS_SIZE; i++) begin
                tag1_q[i]  <= tag1_d[i];
                tag2_q[i]  <= tag2_d[i];
                older_q[i] <= older_d[i];
            end
        end
    end
endmodule
